// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: non-preemptive grants with round-robin tie-break.
// Outputs decode from registered state only, so there is no path from the requests.
module bus_arbiter (
  input  logic clk,
  input  logic rstn,
  input  logic breq1,
  input  logic breq2,
  output logic bgrant1,
  output logic bgrant2,
  output logic msel,
  output logic bbusy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  // Last-served master: 0 = master 1, 1 = master 2. This is also the mux select,
  // which therefore holds its value through IDLE.
  logic   last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == GNT1)
        last <= 1'b0;
      else if (state_nxt == GNT2)
        last <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (breq1 && breq2)
          state_nxt = last ? GNT1 : GNT2;
        else if (breq1)
          state_nxt = GNT1;
        else if (breq2)
          state_nxt = GNT2;
      end
      GNT1: begin
        if (!breq1)
          state_nxt = breq2 ? GNT2 : IDLE;
      end
      GNT2: begin
        if (!breq2)
          state_nxt = breq1 ? GNT1 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bgrant1 = (state == GNT1);
    bgrant2 = (state == GNT2);
    bbusy   = (state != IDLE);
    msel    = last;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, hand-written corner sequences,
// then random held requests against an owner/last-winner reference model.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic breq1 = 1'b0;
  logic breq2 = 1'b0;
  logic bgrant1, bgrant2, msel, bbusy;

  int n_vec = 0;
  int n_bad = 0;

  bus_arbiter dut (
    .clk     (clk),
    .rstn    (rstn),
    .breq1   (breq1),
    .breq2   (breq2),
    .bgrant1 (bgrant1),
    .bgrant2 (bgrant2),
    .msel    (msel),
    .bbusy   (bbusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic       b1;
    logic       b2;
    logic [3:0] exp;   // {bgrant1, bgrant2, msel, bbusy}
  } vec_t;

  vec_t tbl[18];

  // Reference model: current owner (0 none, 1, 2) and last winner (1 or 2).
  int owner = 0;
  int last_winner = 1;

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {bgrant1, bgrant2, msel, bbusy};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: {g1,g2,msel,busy} got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Drive at the falling edge; with reset asserted the outputs are checked
  // right away (asynchronous), otherwise just after the next rising edge.
  task automatic apply(input logic r, input logic b1, input logic b2);
    @(negedge clk);
    rstn  = r;
    breq1 = b1;
    breq2 = b2;
    if (!r)
      #1;
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    owner = 0;
    last_winner = 1;
  endtask

  task automatic model_step(input logic b1, input logic b2);
    if (owner == 0) begin
      if (b1 && b2)      owner = (last_winner == 1) ? 2 : 1;
      else if (b1)       owner = 1;
      else if (b2)       owner = 2;
    end else if (owner == 1 && !b1) begin
      owner = b2 ? 2 : 0;
    end else if (owner == 2 && !b2) begin
      owner = b1 ? 1 : 0;
    end
    if (owner != 0) last_winner = owner;
  endtask

  function automatic logic [3:0] model_out();
    return {owner == 1, owner == 2, last_winner == 2, owner != 0};
  endfunction

  initial begin
    logic r1, r2;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'b0000};  // reset
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 4'b1001};  // single request m1
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'b0000};  // release
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'b0111};  // tie, last=m1 -> m2
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'b1001};  // direct handover
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'b0000};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 4'b0111};  // tie -> m2
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 4'b0111};  // held, no preemption
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 4'b1001};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 4'b0111};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 4'b1001};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 4'b0000};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 4'b0111};  // single request m2
    tbl[13] = '{1'b1, 1'b0, 1'b0, 4'b0010};  // idle, msel holds 1
    tbl[14] = '{1'b1, 1'b1, 1'b1, 4'b1001};  // tie, last=m2 -> m1
    tbl[15] = '{1'b0, 1'b1, 1'b1, 4'b0000};  // reset mid-transaction
    tbl[16] = '{1'b1, 1'b1, 1'b1, 4'b0111};  // last cleared -> m2
    tbl[17] = '{1'b1, 1'b0, 1'b0, 4'b0010};

    repeat (2) @(posedge clk);
    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].rstn, tbl[i].b1, tbl[i].b2);
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Ten cycles of m1 ownership with m2 waiting, then handover.
    apply(1'b1, 1'b1, 1'b0);
    check("hold_start", 4'b1001);
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 1'b1, 1'b1);
      check($sformatf("hold_m1[%0d]", i), 4'b1001);
    end
    apply(1'b1, 1'b0, 1'b1);
    check("hold_handover", 4'b0111);
    apply(1'b1, 1'b0, 1'b0);
    check("hold_idle", 4'b0010);

    // Reset pulsed mid-cycle during GNT2, then re-arbitration from last=0.
    apply(1'b1, 1'b0, 1'b1);
    check("gnt2_before_rst", 4'b0111);
    breq1 = 1'b1;
    @(posedge clk);
    #3 rstn = 1'b0;
    #1 check("async_rst", 4'b0000);
    apply(1'b1, 1'b1, 1'b1);
    check("rearb_after_rst", 4'b0111);
    apply(1'b1, 1'b0, 1'b0);
    check("idle_after_rearb", 4'b0010);

    // A pulse that never meets a rising edge is ignored.
    @(posedge clk);
    #2 breq1 = 1'b1;
    #2 breq1 = 1'b0;
    @(posedge clk);
    #1 check("short_pulse", 4'b0010);

    // Random held requests with occasional reset.
    apply(1'b0, 1'b0, 1'b0);
    model_reset();
    check("rand_reset0", model_out());
    r1 = 1'b0;
    r2 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        apply(1'b0, r1, r2);
        model_reset();
        check($sformatf("rand_rst[%0d]", i), 4'b0000);
      end else begin
        if (r1) r1 = ($urandom_range(0, 3) != 0);
        else    r1 = ($urandom_range(0, 2) == 0);
        if (r2) r2 = ($urandom_range(0, 3) != 0);
        else    r2 = ($urandom_range(0, 2) == 0);
        apply(1'b1, r1, r2);
        model_step(r1, r2);
        check($sformatf("rand[%0d]", i), model_out());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
